// File: rtl/hc_pkg.sv
// Shared hypercube link definitions: element/dimension widths, TX FSM encoding, link beat layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a; the neighbour receiver imports the same definitions.
package hc_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int DIM_W  = 3;
    localparam int LEN_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_t;

    // One beat as seen on the link.
    typedef struct packed {
        logic [DATA_W-1:0] dat;
        logic              last;
        logic [DIM_W-1:0]  dim;
    } beat_t;

    // Requests longer than the bank are cut down to the whole bank.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
    endfunction

endpackage

// File: rtl/hc_reg_bank.sv
// Local element bank: DEPTH x DATA_W registers, one write port, one combinational read port.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none; the owner gates wr_en to freeze contents.
module hc_reg_bank
    import hc_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage: cleared by reset, single-entry write per cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/hc_link_tx.sv
// Hypercube link transmitter: streams the first LEN bank elements to neighbour DIM over valid/ready.
// Latency: TX_VALID 1 cycle after START; 1 beat/cycle at full READY; DONE n+1 cycles after TX_VALID rise.
// Backpressure: TX_READY low holds the current beat stable; bank writes are dropped while not idle.
module hc_link_tx
    import hc_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              WR_EN,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [DATA_W-1:0] WR_DATA,
    input  logic              START,
    input  logic [LEN_W-1:0]  LEN,
    input  logic [DIM_W-1:0]  DIM,
    output logic              TX_VALID,
    input  logic              TX_READY,
    output logic [DATA_W-1:0] TX_DATA,
    output logic              TX_LAST,
    output logic [DIM_W-1:0]  TX_DIM,
    output logic              BUSY,
    output logic              DONE
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    beat_t             beat_q, beat_d;
    logic              vld_q, vld_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              bank_wr_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [LEN_W-1:0]  len_in;

    assign len_in = clamp_len(LEN);

    hc_reg_bank u_bank (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (bank_wr_en),
        .wr_addr (WR_ADDR),
        .wr_data (WR_DATA),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Next-state and next-output logic; the read port looks one element ahead while sending.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        beat_d     = beat_q;
        vld_d      = vld_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bank_wr_en = 1'b0;
        rd_addr    = '0;
        case (state_q)
            IDLE: begin
                // A write to entry 0 in the START cycle lands on this edge, so the
                // first beat still carries the old contents read here.
                bank_wr_en = WR_EN;
                if (START) begin
                    if (len_in == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d     = SEND;
                        len_d       = len_in;
                        idx_d       = '0;
                        beat_d.dat  = rd_data;
                        beat_d.last = (len_in == LEN_W'(1));
                        beat_d.dim  = DIM;
                        vld_d       = 1'b1;
                        busy_d      = 1'b1;
                    end
                end
            end
            SEND: begin
                rd_addr = idx_q + ADDR_W'(1);
                if (vld_q && TX_READY) begin
                    if ({1'b0, idx_q} == len_q - LEN_W'(1)) begin
                        state_d     = FIN;
                        vld_d       = 1'b0;
                        beat_d.last = 1'b0;
                        busy_d      = 1'b0;
                    end else begin
                        idx_d       = idx_q + ADDR_W'(1);
                        beat_d.dat  = rd_data;
                        beat_d.last = (({1'b0, idx_q} + LEN_W'(2)) == len_q);
                    end
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, transfer context and output registers; reset aborts any transfer immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign TX_VALID = vld_q;
    assign TX_DATA  = beat_q.dat;
    assign TX_LAST  = beat_q.last;
    assign TX_DIM   = beat_q.dim;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

endmodule

// File: tb/tb_hc_link_tx.sv
// Directed bench for hc_link_tx: streaming, backpressure, empty transfer, frozen bank, reset abort, write/start overlap.
// Latency: expectations are cycle-exact relative to START.
// Backpressure: TX_READY patterns are driven directly by the bench.
module tb_hc_link_tx;

    logic       CLK = 1'b0;
    logic       RST;
    logic       WR_EN;
    logic [1:0] WR_ADDR;
    logic [7:0] WR_DATA;
    logic       START;
    logic [2:0] LEN;
    logic [2:0] DIM;
    logic       TX_VALID;
    logic       TX_READY;
    logic [7:0] TX_DATA;
    logic       TX_LAST;
    logic [2:0] TX_DIM;
    logic       BUSY;
    logic       DONE;

    int errors = 0;
    int checks = 0;

    hc_link_tx dut (
        .CLK      (CLK),
        .RST      (RST),
        .WR_EN    (WR_EN),
        .WR_ADDR  (WR_ADDR),
        .WR_DATA  (WR_DATA),
        .START    (START),
        .LEN      (LEN),
        .DIM      (DIM),
        .TX_VALID (TX_VALID),
        .TX_READY (TX_READY),
        .TX_DATA  (TX_DATA),
        .TX_LAST  (TX_LAST),
        .TX_DIM   (TX_DIM),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    always #5 CLK = ~CLK;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic bank_write(input logic [1:0] a, input logic [7:0] d);
        WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d;
        step();
        WR_EN = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #2;
        checks++;
        if ({TX_VALID, TX_LAST, TX_DATA, TX_DIM, BUSY, DONE} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {TX_VALID, TX_LAST, TX_DATA, TX_DIM, BUSY, DONE});
        end
        step();
        RST = 1'b0;
        step();
        checks++;
        if ({TX_VALID, BUSY, DONE} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: got %b expected 000", {TX_VALID, BUSY, DONE});
        end
    endtask

    task automatic test_stream();
        logic [12:0] exp;
        bank_write(2'd0, 8'h11);
        bank_write(2'd1, 8'h22);
        bank_write(2'd2, 8'h33);
        bank_write(2'd3, 8'h44);
        START = 1'b1; LEN = 3'd4; DIM = 3'd5; TX_READY = 1'b1;
        step();
        START = 1'b0; LEN = 3'd0;
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL stream_busy: got %b expected 1", BUSY);
        end
        for (int k = 0; k < 4; k++) begin
            exp = {1'b1, (k == 3), 3'd5, 8'(8'h11 * (k + 1))};
            checks++;
            if ({TX_VALID, TX_LAST, TX_DIM, TX_DATA} !== exp) begin
                errors++;
                $display("FAIL stream_beat%0d: got %h expected %h", k, {TX_VALID, TX_LAST, TX_DIM, TX_DATA}, exp);
            end
            step();
        end
        checks++;
        if ({TX_VALID, TX_LAST, DONE} !== 3'b000) begin
            errors++;
            $display("FAIL stream_after_last: got %b expected 000", {TX_VALID, TX_LAST, DONE});
        end
        step();
        checks++;
        if ({DONE, BUSY} !== 2'b10) begin
            errors++;
            $display("FAIL stream_done: got %b expected 10", {DONE, BUSY});
        end
        step();
        checks++;
        if (DONE !== 1'b0) begin
            errors++;
            $display("FAIL stream_done_pulse: got %b expected 0", DONE);
        end
    endtask

    task automatic test_backpressure();
        logic [4:0]  pat = 5'b11001;
        int          ptr = 0;
        logic [12:0] exp;
        START = 1'b1; LEN = 3'd3; DIM = 3'd5; TX_READY = 1'b1;
        step();
        START = 1'b0;
        for (int i = 0; i < 5; i++) begin
            TX_READY = pat[i];
            exp = {1'b1, (ptr == 2), 3'd5, 8'(8'h11 * (ptr + 1))};
            checks++;
            if ({TX_VALID, TX_LAST, TX_DIM, TX_DATA} !== exp) begin
                errors++;
                $display("FAIL bp_cycle%0d: got %h expected %h", i, {TX_VALID, TX_LAST, TX_DIM, TX_DATA}, exp);
            end
            step();
            if (pat[i]) ptr++;
        end
        TX_READY = 1'b1;
        checks++;
        if (TX_VALID !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_extra_beat: got %b expected 0", TX_VALID);
        end
        step();
        checks++;
        if (DONE !== 1'b1) begin
            errors++;
            $display("FAIL bp_done: got %b expected 1", DONE);
        end
        step();
    endtask

    task automatic test_len_zero();
        START = 1'b1; LEN = 3'd0; DIM = 3'd6;
        step();
        START = 1'b0;
        checks++;
        if ({TX_VALID, BUSY, DONE} !== 3'b000) begin
            errors++;
            $display("FAIL len0_cycle1: got %b expected 000", {TX_VALID, BUSY, DONE});
        end
        step();
        checks++;
        if ({TX_VALID, BUSY, DONE} !== 3'b001) begin
            errors++;
            $display("FAIL len0_done: got %b expected 001", {TX_VALID, BUSY, DONE});
        end
        step();
        checks++;
        if (DONE !== 1'b0) begin
            errors++;
            $display("FAIL len0_done_pulse: got %b expected 0", DONE);
        end
    endtask

    task automatic test_frozen_bank();
        logic [12:0] exp;
        START = 1'b1; LEN = 3'd4; DIM = 3'd2; TX_READY = 1'b1;
        step();
        WR_EN = 1'b1; WR_ADDR = 2'd1; WR_DATA = 8'hAA;
        LEN = 3'd1; DIM = 3'd7;
        for (int k = 0; k < 4; k++) begin
            exp = {1'b1, (k == 3), 3'd2, 8'(8'h11 * (k + 1))};
            checks++;
            if ({TX_VALID, TX_LAST, TX_DIM, TX_DATA} !== exp) begin
                errors++;
                $display("FAIL frozen_beat%0d: got %h expected %h", k, {TX_VALID, TX_LAST, TX_DIM, TX_DATA}, exp);
            end
            step();
            WR_EN = 1'b0; START = 1'b0;
        end
        step();
        checks++;
        if (DONE !== 1'b1) begin
            errors++;
            $display("FAIL frozen_done: got %b expected 1", DONE);
        end
        step();
        START = 1'b1; LEN = 3'd2; DIM = 3'd1;
        step();
        START = 1'b0;
        step();
        checks++;
        if ({TX_VALID, TX_LAST, TX_DIM, TX_DATA} !== {1'b1, 1'b1, 3'd1, 8'h22}) begin
            errors++;
            $display("FAIL frozen_addr1: got %h expected %h", {TX_VALID, TX_LAST, TX_DIM, TX_DATA}, {1'b1, 1'b1, 3'd1, 8'h22});
        end
        step();
        step();
        step();
    endtask

    task automatic test_reset_abort();
        START = 1'b1; LEN = 3'd4; DIM = 3'd3; TX_READY = 1'b1;
        step();
        START = 1'b0;
        step();
        TX_READY = 1'b0;
        step();
        checks++;
        if ({TX_VALID, TX_DATA} !== {1'b1, 8'h22}) begin
            errors++;
            $display("FAIL abort_pending: got %h expected %h", {TX_VALID, TX_DATA}, {1'b1, 8'h22});
        end
        RST = 1'b1;
        #1;
        checks++;
        if ({TX_VALID, TX_LAST, TX_DATA, TX_DIM, BUSY, DONE} !== 15'd0) begin
            errors++;
            $display("FAIL abort_outputs: got %h expected 0", {TX_VALID, TX_LAST, TX_DATA, TX_DIM, BUSY, DONE});
        end
        step();
        RST = 1'b0;
        TX_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({TX_VALID, BUSY, DONE} !== 3'b000) begin
                errors++;
                $display("FAIL abort_quiet%0d: got %b expected 000", i, {TX_VALID, BUSY, DONE});
            end
        end
        START = 1'b1; LEN = 3'd1; DIM = 3'd4;
        step();
        START = 1'b0;
        checks++;
        if ({TX_VALID, TX_LAST, TX_DIM, TX_DATA} !== {1'b1, 1'b1, 3'd4, 8'h00}) begin
            errors++;
            $display("FAIL abort_bank_cleared: got %h expected %h", {TX_VALID, TX_LAST, TX_DIM, TX_DATA}, {1'b1, 1'b1, 3'd4, 8'h00});
        end
        step();
        step();
        checks++;
        if (DONE !== 1'b1) begin
            errors++;
            $display("FAIL abort_next_done: got %b expected 1", DONE);
        end
        step();
    endtask

    task automatic test_write_start_overlap();
        bank_write(2'd0, 8'h11);
        WR_EN = 1'b1; WR_ADDR = 2'd0; WR_DATA = 8'h5A;
        START = 1'b1; LEN = 3'd1; DIM = 3'd6;
        step();
        WR_EN = 1'b0; START = 1'b0;
        checks++;
        if ({TX_VALID, TX_LAST, TX_DIM, TX_DATA} !== {1'b1, 1'b1, 3'd6, 8'h11}) begin
            errors++;
            $display("FAIL overlap_old_data: got %h expected %h", {TX_VALID, TX_LAST, TX_DIM, TX_DATA}, {1'b1, 1'b1, 3'd6, 8'h11});
        end
        step();
        step();
        step();
        START = 1'b1; LEN = 3'd1; DIM = 3'd6;
        step();
        START = 1'b0;
        checks++;
        if ({TX_VALID, TX_LAST, TX_DIM, TX_DATA} !== {1'b1, 1'b1, 3'd6, 8'h5A}) begin
            errors++;
            $display("FAIL overlap_new_data: got %h expected %h", {TX_VALID, TX_LAST, TX_DIM, TX_DATA}, {1'b1, 1'b1, 3'd6, 8'h5A});
        end
        step();
        step();
        step();
    endtask

    task automatic test_len_clamp();
        logic [12:0] exp;
        bank_write(2'd1, 8'h01);
        bank_write(2'd2, 8'h02);
        bank_write(2'd3, 8'h03);
        START = 1'b1; LEN = 3'd7; DIM = 3'd0; TX_READY = 1'b1;
        step();
        START = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp = {1'b1, (k == 3), 3'd0, (k == 0) ? 8'h5A : 8'(k)};
            checks++;
            if ({TX_VALID, TX_LAST, TX_DIM, TX_DATA} !== exp) begin
                errors++;
                $display("FAIL clamp_beat%0d: got %h expected %h", k, {TX_VALID, TX_LAST, TX_DIM, TX_DATA}, exp);
            end
            step();
        end
        checks++;
        if (TX_VALID !== 1'b0) begin
            errors++;
            $display("FAIL clamp_no_fifth: got %b expected 0", TX_VALID);
        end
        step();
        checks++;
        if (DONE !== 1'b1) begin
            errors++;
            $display("FAIL clamp_done: got %b expected 1", DONE);
        end
        step();
    endtask

    initial begin
        RST = 1'b1; WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0;
        START = 1'b0; LEN = '0; DIM = '0; TX_READY = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_len_zero();
        test_frozen_bank();
        test_reset_abort();
        test_write_start_overlap();
        test_len_clamp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
